// File: rtl/ntt_pkg.sv
// Shared types and default sizes for the NTT result drain stage.
package ntt_pkg;

  localparam int NTT_N  = 64;
  localparam int NTT_DW = 64;

  typedef logic [NTT_DW-1:0] ntt_word_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } drain_state_t;

endpackage

// File: rtl/ntt_drain_fifo.sv
// First-word-fall-through synchronous FIFO holding result words plus their last tag.
module ntt_drain_fifo
  import ntt_pkg::*;
#(
  parameter int W = NTT_DW + 1,
  parameter int D = 4,
  localparam int PW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= din;
  end

  // Pointer and occupancy tracking; a push and pop together leave the count alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= nextPtr(r_wptr);
      if (pop)  r_rptr <= nextPtr(r_rptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/ntt_result_drain.sv
// Reads the N-word NTT result out of the data BRAM and streams it on valid/ready.
module ntt_result_drain
  import ntt_pkg::*;
#(
  parameter int N      = NTT_N,
  parameter int DW     = NTT_DW,
  parameter int AW     = 10,
  parameter int RD_LAT = 3,
  parameter int FDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ntt_done,
  output logic [AW-1:0] BRAM_addr_2,
  output logic          BRAM_clk_2,
  output logic          BRAM_en_2,
  input  logic [DW-1:0] BRAM_dout_2,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          busy,
  output logic          drain_done
);

  localparam int IW = $clog2(N) + 1;
  localparam int CW = $clog2(FDEPTH + 1);
  localparam int OW = $clog2(FDEPTH + RD_LAT + 1) + 1;

  drain_state_t    r_state;
  drain_state_t    w_next;
  logic            r_done_q;
  logic            w_start;
  logic [IW-1:0]   r_rd_idx;
  logic [RD_LAT-1:0] r_vld_sr;
  logic [RD_LAT-1:0] r_tag_sr;
  logic            w_issue;
  logic            w_last_idx;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [OW-1:0]   w_inflight;
  logic [OW-1:0]   w_occupancy;
  logic [DW:0]     w_fifo_dout;

  assign w_start    = ntt_done & ~r_done_q;
  assign w_last_idx = (r_rd_idx == IW'(N - 1));
  assign w_pop      = m_tvalid & m_tready;
  assign w_push     = r_vld_sr[RD_LAT-1];

  // Remember last ntt_done level so only a rising edge starts a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done_q <= 1'b0;
    else      r_done_q <= ntt_done;
  end

  // Drain state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Reserved FIFO slots: words already queued plus reads still in the BRAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + OW'(r_vld_sr[i]);
    end
    w_occupancy = OW'(w_count) + w_inflight;
  end

  // Next state and issue decision; a slot freed by this cycle's pop counts as a credit,
  // which is what lets the drain sustain one word per cycle.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE:  if (w_start) w_next = READ;
      READ: begin
        w_issue = (w_occupancy < (OW'(FDEPTH) + OW'(w_pop)));
        if (w_issue && w_last_idx) w_next = FLUSH;
      end
      FLUSH: if (w_pop && m_tlast) w_next = DONE;
      DONE:  if (!ntt_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read index: restarts at zero on every accepted start, advances on each issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            r_rd_idx <= '0;
    else if (r_state == IDLE && w_start) r_rd_idx <= '0;
    else if (w_issue)                    r_rd_idx <= r_rd_idx + IW'(1);
  end

  // Valid and last-tag pipeline that lines up with the BRAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_sr <= '0;
      r_tag_sr <= '0;
    end else begin
      r_vld_sr <= (r_vld_sr << 1) | RD_LAT'(w_issue);
      r_tag_sr <= (r_tag_sr << 1) | RD_LAT'(w_issue & w_last_idx);
    end
  end

  ntt_drain_fifo #(
    .W (DW + 1),
    .D (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({r_tag_sr[RD_LAT-1], BRAM_dout_2}),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .count (w_count)
  );

  assign BRAM_clk_2  = clk;
  assign BRAM_en_2   = w_issue;
  assign BRAM_addr_2 = w_issue ? AW'({r_rd_idx, 2'b00}) : '0;

  assign m_tvalid   = ~w_empty;
  assign m_tdata    = w_fifo_dout[DW-1:0];
  assign m_tlast    = ~w_empty & w_fifo_dout[DW];
  assign busy       = (r_state == READ) || (r_state == FLUSH);
  assign drain_done = (r_state == DONE);

endmodule

// File: tb/tb_ntt_result_drain.sv
// Self-checking bench for ntt_result_drain with a modelled 3-cycle BRAM and a scoreboard.
module tb_ntt_result_drain;

  localparam int N      = 64;
  localparam int DW     = 64;
  localparam int AW     = 10;
  localparam int RD_LAT = 3;
  localparam int FDEPTH = 4;

  logic          clk;
  logic          rst;
  logic          ntt_done;
  logic [AW-1:0] BRAM_addr_2;
  logic          BRAM_clk_2;
  logic          BRAM_en_2;
  logic [DW-1:0] BRAM_dout_2;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          drain_done;

  ntt_result_drain #(
    .N(N), .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FDEPTH(FDEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ntt_done    (ntt_done),
    .BRAM_addr_2 (BRAM_addr_2),
    .BRAM_clk_2  (BRAM_clk_2),
    .BRAM_en_2   (BRAM_en_2),
    .BRAM_dout_2 (BRAM_dout_2),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .busy        (busy),
    .drain_done  (drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] wordOf(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  // BRAM model: three register stages from the enable/address to the data output.
  logic [DW-1:0] bramP0, bramP1, bramP2;
  always @(posedge BRAM_clk_2) begin
    bramP0 <= BRAM_en_2 ? wordOf(int'(BRAM_addr_2[AW-1:2])) : 64'hDEAD_BEEF_DEAD_BEEF;
    bramP1 <= bramP0;
    bramP2 <= bramP1;
  end
  assign BRAM_dout_2 = bramP2;

  int checks = 0;
  int errors = 0;

  // Scoreboard state: what has been issued and accepted in the current drain.
  int          issueCnt;
  int          acceptCnt;
  logic        prevStall;
  logic [63:0] prevData;
  int          cyc;
  logic        doneIn;

  logic        recBusy  [80];
  logic        recValid [80];
  logic        recLast  [80];
  logic        recDone  [80];
  logic        recEn    [80];
  logic [63:0] recData  [80];

  typedef struct {
    int   offset;
    logic expBusy;
    logic expValid;
    logic expLast;
    logic expDoneOut;
    logic expEn;
    int   expWord;
  } vec_t;

  vec_t steadyTable[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic beginDrain();
    issueCnt  = 0;
    acceptCnt = 0;
    prevStall = 1'b0;
    prevData  = '0;
    cyc       = 0;
  endtask

  // One clock of stimulus, then scoreboard the outputs half a cycle away from the edge.
  task automatic applyStimulus(input logic doneV, input logic readyV);
    logic hs;
    @(negedge clk);
    ntt_done = doneV;
    m_tready = readyV;
    #1;
    hs = m_tvalid && m_tready;
    checkOutput("bramClk", 64'(BRAM_clk_2), 64'(clk));
    if (BRAM_en_2) begin
      checkOutput("issueAddr", 64'(BRAM_addr_2), 64'(issueCnt * 4));
      issueCnt++;
      checkOutput("issueBound", 64'(issueCnt <= N), 64'(1));
    end
    if (prevStall) begin
      checkOutput("holdValid", 64'(m_tvalid), 64'(1));
      checkOutput("holdData", m_tdata, prevData);
    end
    if (hs) begin
      checkOutput("wordData", m_tdata, wordOf(acceptCnt));
      checkOutput("wordLast", 64'(m_tlast), 64'(acceptCnt == N - 1));
      acceptCnt++;
    end
    checkOutput("creditLimit", 64'((issueCnt - acceptCnt) <= FDEPTH), 64'(1));
    prevStall = m_tvalid && !m_tready;
    prevData  = m_tdata;
    if (cyc < 80) begin
      recBusy[cyc]  = busy;
      recValid[cyc] = m_tvalid;
      recLast[cyc]  = m_tlast;
      recDone[cyc]  = drain_done;
      recEn[cyc]    = BRAM_en_2;
      recData[cyc]  = m_tdata;
    end
    cyc++;
  endtask

  task automatic runDrain(input int readyPct, input int stallCycles, input int dropAtWord,
                          input bit spurious);
    int   n;
    bit   seen;
    logic rdy;
    n    = 0;
    seen = 1'b0;
    doneIn = 1'b1;
    while (!seen && n < 3000) begin
      if (n < stallCycles)      rdy = 1'b0;
      else if (readyPct >= 100) rdy = 1'b1;
      else                      rdy = ($urandom_range(0, 99) < readyPct);
      if (dropAtWord >= 0 && acceptCnt >= dropAtWord) doneIn = 1'b0;
      if (spurious) doneIn = !(n == 10 || n == 11 || n == 25);
      applyStimulus(doneIn, rdy);
      if (stallCycles > 0 && n == stallCycles - 1)
        checkOutput("stallIssues", 64'(issueCnt), 64'(FDEPTH));
      if (drain_done) seen = 1'b1;
      n++;
    end
    checkOutput("drainFinished", 64'(seen), 64'(1));
    checkOutput("wordsAccepted", 64'(acceptCnt), 64'(N));
    checkOutput("wordsIssued", 64'(issueCnt), 64'(N));
  endtask

  task automatic finishDrain(input int steps);
    doneIn = 1'b0;
    repeat (steps) applyStimulus(1'b0, 1'b1);
    checkOutput("idleDone", 64'(drain_done), 64'(0));
    checkOutput("idleBusy", 64'(busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    steadyTable[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1};
    steadyTable[1] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1};
    steadyTable[2] = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1};
    steadyTable[3] = '{5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    steadyTable[4] = '{6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    steadyTable[5] = '{64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 59};
    steadyTable[6] = '{65, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 60};
    steadyTable[7] = '{68, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 63};
    steadyTable[8] = '{69, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1};
    steadyTable[9] = '{72, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1};

    rst      = 1'b0;
    ntt_done = 1'b0;
    m_tready = 1'b0;
    doneIn   = 1'b0;
    beginDrain();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstAddr", 64'(BRAM_addr_2), 64'(0));
    checkOutput("rstEn", 64'(BRAM_en_2), 64'(0));
    checkOutput("rstValid", 64'(m_tvalid), 64'(0));
    checkOutput("rstLast", 64'(m_tlast), 64'(0));
    checkOutput("rstBusy", 64'(busy), 64'(0));
    checkOutput("rstDrainDone", 64'(drain_done), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("idleNoIssue", 64'(issueCnt), 64'(0));

    $display("[TB] steady drain");
    beginDrain();
    runDrain(100, 0, -1, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      n = steadyTable[i].offset;
      checkOutput($sformatf("steadyBusy@%0d", n), 64'(recBusy[n]), 64'(steadyTable[i].expBusy));
      checkOutput($sformatf("steadyValid@%0d", n), 64'(recValid[n]), 64'(steadyTable[i].expValid));
      checkOutput($sformatf("steadyLast@%0d", n), 64'(recLast[n]), 64'(steadyTable[i].expLast));
      checkOutput($sformatf("steadyDone@%0d", n), 64'(recDone[n]), 64'(steadyTable[i].expDoneOut));
      checkOutput($sformatf("steadyEn@%0d", n), 64'(recEn[n]), 64'(steadyTable[i].expEn));
      if (steadyTable[i].expWord >= 0)
        checkOutput($sformatf("steadyData@%0d", n), recData[n], wordOf(steadyTable[i].expWord));
    end
    finishDrain(2);

    $display("[TB] random back-pressure");
    beginDrain();
    runDrain(30, 0, -1, 1'b0);
    finishDrain(2);

    $display("[TB] full stall");
    beginDrain();
    runDrain(100, 20, -1, 1'b0);
    finishDrain(2);

    $display("[TB] ntt_done drop mid-drain");
    beginDrain();
    runDrain(100, 0, 30, 1'b0);
    finishDrain(1);

    $display("[TB] fresh drain then async reset");
    beginDrain();
    n = 0;
    while (acceptCnt < 17 && n < 200) begin
      applyStimulus(1'b1, 1'b1);
      n++;
    end
    checkOutput("reachedWord17", 64'(acceptCnt), 64'(17));
    #1;
    rst = 1'b0;
    #1;
    checkOutput("asyncValid", 64'(m_tvalid), 64'(0));
    checkOutput("asyncBusy", 64'(busy), 64'(0));
    checkOutput("asyncEn", 64'(BRAM_en_2), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    beginDrain();
    runDrain(100, 0, -1, 1'b0);
    finishDrain(2);

    $display("[TB] spurious start during read");
    beginDrain();
    runDrain(100, 0, -1, 1'b1);
    finishDrain(2);
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("noSecondDrain", 64'(issueCnt), 64'(N));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
